// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: round-robin tie break with a bounded
// hold per grant so a streaming requester cannot starve the other port.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [7:0]  r_hold_cnt;
  logic        r_rv0;
  logic        r_rv1;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_chg;
  logic        w_sat;

  assign w_acc0 = (r_state == S_GNT0) && req0;
  assign w_acc1 = (r_state == S_GNT1) && req1;
  assign w_chg  = (w_next != r_state);
  assign w_sat  = (r_hold_cnt == HOLD_LAST);
  assign rdata  = mem_rdata;
  assign rvalid0 = r_rv0;
  assign rvalid1 = r_rv1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_hold_cnt <= 8'd0;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_chg && w_next == S_GNT0) r_last <= 1'b0;
      if (w_chg && w_next == S_GNT1) r_last <= 1'b1;
      if (w_chg)
        r_hold_cnt <= 8'd0;
      else if ((w_acc0 || w_acc1) && !w_sat)
        r_hold_cnt <= r_hold_cnt + 8'd1;
      // rvalid follows the access, not the grant, so a switch keeps it
      r_rv0 <= w_acc0 && !we0;
      r_rv1 <= w_acc1 && !we1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req0 && (!req1 || r_last)) w_next = S_GNT0;
        else if (req1)                 w_next = S_GNT1;
      end
      S_GNT0: begin
        if (!req0)              w_next = req1 ? S_GNT1 : S_IDLE;
        else if (req1 && w_sat) w_next = S_GNT1;
      end
      S_GNT1: begin
        if (!req1)              w_next = req0 ? S_GNT0 : S_IDLE;
        else if (req0 && w_sat) w_next = S_GNT0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt0      = (r_state == S_GNT0);
    gnt1      = (r_state == S_GNT1);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_acc0: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      w_acc1: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; read data is checked by a queue
// scoreboard, grant/bus behaviour by inline directed checks.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [15:0] rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 0;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  logic [15:0] ram [0:255];
  bit   [255:0] wr_done;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h05:   return 16'h1234;
      8'h10:   return 16'hA010;
      8'h11:   return 16'hB011;
      8'h21:   return 16'hC021;
      8'h30:   return 16'hD030;
      8'h40:   return 16'hE040;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) begin
    mem_rdata <= wr_done[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      wr_done[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
      else chk("rdata_port0", rdata, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
      else chk("rdata_port1", rdata, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seen;
    // reset state with a write request pending on the inputs
    req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 16'h7777;
    repeat (2) @(negedge clock);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_hold", dut.r_hold_cnt, 0);
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    @(posedge clock); #1 reset = 1'b1;

    // basic read
    req0 = 1; we0 = 0; addr0 = 8'h05;
    q0.push_back(16'h1234);
    chk("rd_pre_gnt0", gnt0, 0);
    tick();
    chk("rd_gnt0", gnt0, 1);
    chk("rd_mem_addr", mem_addr, 8'h05);
    chk("rd_mem_we", mem_we, 0);
    tick();
    req0 = 0;
    repeat (3) tick();

    // tie after reset: port 0 first, then port 1 with no idle gap
    do_reset();
    req0 = 1; addr0 = 8'h10; req1 = 1; we1 = 0; addr1 = 8'h11;
    q0.push_back(16'hA010);
    tick();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1_low", gnt1, 0);
    tick();
    req0 = 0;
    q1.push_back(16'hB011);
    tick();
    chk("tie_switch_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    repeat (3) tick();

    // starvation bound
    do_reset();
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 16'h1111;
    req1 = 1; we1 = 0; addr1 = 8'h21;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (gnt1) begin seen = 1; break; end
      if (gnt0 && mem_we && mem_addr == 8'h20) cnt++;
    end
    chk("starve_switched", seen, 1);
    chk("starve_p0_accesses", cnt, 8);
    chk("starve_hold_clear", dut.r_hold_cnt, 0);
    chk("starve_gnt0_low", gnt0, 0);
    q1.push_back(16'hC021);
    tick();
    req0 = 0; we0 = 0; req1 = 0;
    repeat (3) tick();

    // unopposed hold on port 1
    req1 = 1; we1 = 0; addr1 = 8'h30;
    tick();
    cnt = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (gnt1) seen++;
      if (gnt1 && !mem_we && mem_addr == 8'h30) cnt++;
      q1.push_back(16'hD030);
      tick();
    end
    chk("hold_gnt1_cycles", seen, 20);
    chk("hold_accesses", cnt, 20);
    chk("hold_saturated", dut.r_hold_cnt, 7);
    req1 = 0;
    repeat (3) tick();

    // write path then read back from the other port
    req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 16'hBEEF;
    tick();
    @(negedge clock);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h80);
    chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    req1 = 0; we1 = 0;
    @(negedge clock);
    chk("wr_we_one_cycle", mem_we, 0);
    chk("wr_addr_idle", mem_addr, 0);
    tick();
    req0 = 1; we0 = 0; addr0 = 8'h80;
    q0.push_back(16'hBEEF);
    tick();
    tick();
    req0 = 0;
    repeat (3) tick();

    // reset in the middle of a port 1 read
    req1 = 1; we1 = 0; addr1 = 8'h40;
    tick();
    chk("mid_gnt1_before", gnt1, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_gnt1_cleared", gnt1, 0);
    chk("mid_mem_we", mem_we, 0);
    chk("mid_mem_addr", mem_addr, 0);
    chk("mid_rvalid1", rvalid1, 0);
    tick();
    chk("mid_rvalid1_held", rvalid1, 0);
    tick();
    reset = 1'b1;
    chk("mid_release_gnt1", gnt1, 0);
    q1.push_back(16'hE040);
    tick();
    chk("mid_regrant_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    repeat (4) tick();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
